alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered, parametrised ALU decode stage for MJ32. It accepts one 32-bit instruction per cycle through a valid/ready handshake. For OP, OP-IMM, OP-32 and OP-IMM-32 instructions it produces the ALU operation code, register indices, the sign-extended immediate and an illegal flag. It sits between fetch and execute, and a two-entry skid buffer keeps `in_ready` registered.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; 64 enables the OP-32/OP-IMM-32 (W) forms.
- `ENABLE_M`, 1: decode the M-extension (funct7 = 0000001) when 1; illegal otherwise.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  drop all buffered entries this edge.
- `in_valid`  in  1  instruction present.
- `in_instr`  in  32  raw instruction.
- `in_ready`  out  1  stage can accept; registered.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  execute accepts.
- `out_op`  out  5  ALU op code (package `alu_op_t`).
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_imm`  out  XLEN  I-type immediate, sign-extended; 0 for register forms.
- `out_use_imm`  out  1  operand B is `out_imm`.
- `out_is_word`  out  1  W-form; result is sign-extended from bit 31 (always 0 when XLEN=32).
- `out_illegal`  out  1  unsupported encoding; `out_op` = NONE.

## Operation
- Op codes are fixed:
  - NONE=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10.
  - With ENABLE_M: MUL=11, MULH=12, MULHSU=13, MULHU=14, DIV=15, DIVU=16, REM=17, REMU=18.
- Decode key is {funct7, funct3} plus opcode.
- OP (0110011):
  - funct7 0000000 with any funct3 gives the base ops.
  - funct7 0100000 is valid only with funct3 000 (SUB) or 101 (SRA).
  - funct7 0000001 gives the M ops when ENABLE_M=1.
- OP-IMM (0010011):
  - funct3 000, 010, 011, 100, 110 and 111 give ADD, SLT, SLTU, XOR, OR and AND with `use_imm`=1.
  - No SUB form exists.
- OP-IMM shifts:
  - funct3 001 gives SLL; 101 gives SRL or SRA, selected by instr[30].
  - The upper shamt bit instr[25] must be 0 when XLEN=32, else illegal.
  - For XLEN=64, instr[31:26] must be 000000 or 010000 (SRA only).
- W forms (XLEN=64 only):
  - OP-32 (0111011) allows ADD, SUB, SLL, SRL, SRA, plus MUL, DIV, DIVU, REM, REMU when ENABLE_M=1.
  - OP-IMM-32 (0011011) allows ADDI, SLLI, SRLI and SRAI, with instr[25]=0 required.
  - All W forms set `is_word`=1.
- Any other opcode or combination sets `illegal`=1 and `op`=NONE; the indices are still passed through.
- The decoder is a combinational function in front of the buffer. Only decoded fields are stored; raw instructions are not.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, buffer count 0.
  - `out_op`=NONE; all other outputs 0.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N, when the buffer is empty.
- Transfer rules:
  - Input transfer happens when `in_valid && in_ready`.
  - Output transfer happens when `out_valid && out_ready`.
- Throughput is 1 per cycle while `out_ready`=1.
- Buffer has two entries: a main output register and a skid register.
  - `in_ready` = (count < 2), computed from registered count.
- Simultaneous input and output transfer:
  - count unchanged; ordering preserved.
  - The skid entry moves to the output first, then the new entry fills in behind it.
- Output stability: while `out_valid && !out_ready`, every `out_*` holds stable.
- Flush:
  - At the edge, count becomes 0, `out_valid`=0 and `in_ready`=1.
  - An input offered in the same cycle is discarded.
  - Flush takes priority over both transfers.
- `rst` asserted mid-stream behaves as flush and also clears all payload registers to their reset values.
- `in_instr` is ignored while `in_valid`=0.

## Structure
- Shared package `mj32_pkg`:
  - `alu_op_t` (5-bit enum).
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_OP_32`, `OPC_OP_IMM_32`.
  - Packed struct `alu_dec_t` {op, rd, rs1, rs2, imm, use_imm, is_word, illegal}.
- One sub-module, `alu_op_decoder`: purely combinational, takes instr and returns `alu_dec_t`. It is parametrised with XLEN and ENABLE_M.
- The top level holds only the two-entry buffer and the count/valid logic.

## Test plan
- Reset, then `in_instr`=0x40B50533 (sub a0,a0,a1) with `out_ready`=1. Next cycle: `out_op`=2, rd=10, rs1=10, rs2=11, `use_imm`=0, `illegal`=0.
- `in_instr`=0xFFF50513 (addi a0,a0,-1), XLEN=64. Expect `out_op`=1, `use_imm`=1, `out_imm`=0xFFFF_FFFF_FFFF_FFFF.
- ENABLE_M=0 with 0x02B50533 (mul). Expect `illegal`=1 and `out_op`=0; with ENABLE_M=1 the same word gives `out_op`=11.
- Back-pressure:
  - Stream 4 back-to-back instructions with `out_ready`=0.
  - Expect `in_ready` to drop after 2 accepts, outputs to hold the first entry, and then drain in order once `out_ready`=1.
- With count=2, assert `flush` and `in_valid` in the same cycle. Next cycle: `out_valid`=0, `in_ready`=1, and nothing is ever emitted for the flushed or offered entries.
- XLEN=32 with 0x02051513 (slli, shamt bit 5 set). Expect `illegal`=1; 0x4015551B (sraiw) also gives `illegal`=1 at XLEN=32.

Source files
------------

// File: rtl/mj32_pkg.sv
// Shared MJ32 decode types: ALU op codes, major opcodes and the decoded-entry record
// passed from the combinational decoder into the decode-stage buffer.
package mj32_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_NONE   = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_SLL    = 5'd3,
        ALU_SLT    = 5'd4,
        ALU_SLTU   = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_OR     = 5'd9,
        ALU_AND    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_t;

    // imm keeps only the raw 12-bit I-immediate; widening to XLEN happens at the stage output
    typedef struct packed {
        alu_op_t    op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [11:0] imm;
        logic       use_imm;
        logic       is_word;
        logic       illegal;
    } alu_dec_t;

    localparam alu_dec_t DEC_RESET = '{op: ALU_NONE, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                       imm: 12'd0, use_imm: 1'b0, is_word: 1'b0,
                                       illegal: 1'b0};

    function automatic alu_op_t base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t muldiv_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side instruction handshake and execute-side decoded-entry handshake of the
// ALU decode stage. master = surrounding pipeline, slave = the decode stage.
interface alu_decode_stage_if import mj32_pkg::*; #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    alu_op_t         out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_is_word;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_use_imm, out_is_word, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_use_imm, out_is_word, out_illegal
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational MJ32 ALU decoder for OP, OP-IMM, OP-32 and OP-IMM-32.
// Anything it does not recognise comes out as ALU_NONE with illegal set.
module alu_op_decoder import mj32_pkg::*; #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output alu_dec_t    dec
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [5:0] funct6;
    logic [2:0] funct3;
    logic       shamt_ok;
    logic       legal;
    alu_op_t    op;
    logic       use_imm;
    logic       is_word;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct6 = instr[31:26];
    // instr[25] is shamt[5] on RV64 and must stay clear on RV32
    assign shamt_ok = (XLEN == 64) || !instr[25];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        op      = ALU_NONE;
        use_imm = 1'b0;
        is_word = 1'b0;

        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: op = base_op(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      op = ALU_SUB;
                        else if (funct3 == 3'b101) op = ALU_SRA;
                    end
                    F7_MULDIV: if (ENABLE_M) op = muldiv_op(funct3);
                    default: ;
                endcase
            end

            OPC_OP_IMM: begin
                use_imm = 1'b1;
                case (funct3)
                    3'b001: if (shamt_ok && funct6 == 6'b000000) op = ALU_SLL;
                    3'b101: begin
                        if (shamt_ok && funct6 == 6'b000000)      op = ALU_SRL;
                        else if (shamt_ok && funct6 == 6'b010000) op = ALU_SRA;
                    end
                    default: op = base_op(funct3);
                endcase
            end

            OPC_OP_32: begin
                if (XLEN == 64) begin
                    is_word = 1'b1;
                    case ({funct7, funct3})
                        {F7_BASE, 3'b000}: op = ALU_ADD;
                        {F7_ALT,  3'b000}: op = ALU_SUB;
                        {F7_BASE, 3'b001}: op = ALU_SLL;
                        {F7_BASE, 3'b101}: op = ALU_SRL;
                        {F7_ALT,  3'b101}: op = ALU_SRA;
                        {F7_MULDIV, 3'b000}, {F7_MULDIV, 3'b100}, {F7_MULDIV, 3'b101},
                        {F7_MULDIV, 3'b110}, {F7_MULDIV, 3'b111}:
                            if (ENABLE_M) op = muldiv_op(funct3);
                        default: ;
                    endcase
                end
            end

            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    use_imm = 1'b1;
                    is_word = 1'b1;
                    case (funct3)
                        3'b000: op = ALU_ADD;
                        3'b001: if (funct7 == F7_BASE) op = ALU_SLL;
                        3'b101: begin
                            if (funct7 == F7_BASE)     op = ALU_SRL;
                            else if (funct7 == F7_ALT) op = ALU_SRA;
                        end
                        default: ;
                    endcase
                end
            end

            default: ;
        endcase

        legal       = (op != ALU_NONE);
        dec.op      = op;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.imm     = (legal && use_imm) ? instr[31:20] : 12'd0;
        dec.use_imm = legal && use_imm;
        dec.is_word = legal && is_word;
        dec.illegal = !legal;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// MJ32 ALU decode stage: combinational decoder feeding a two-entry (main + skid)
// buffer so in_ready comes straight from a register.
module alu_decode_stage import mj32_pkg::*; #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_decode_stage_if.slave  bus
);

    alu_dec_t   dec;
    alu_dec_t   main_q;
    alu_dec_t   skid_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    alu_op_decoder #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .instr (bus.in_instr),
        .dec   (dec)
    );

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload is reset as well, so after rst every out_* is defined, not stale.
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= DEC_RESET;
            skid_q      <= DEC_RESET;
        end else if (flush) begin
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking updates let main_q take skid_q's pre-edge value in the same edge.
            count_q     <= count_d;
            out_valid_q <= (count_d != 2'd0);
            in_ready_q  <= (count_d != 2'd2);
            // a full buffer never accepts, so push with pop always means count_q == 1
            if (push && (count_q == 2'd0 || pop)) main_q <= dec;
            else if (pop && count_q == 2'd2)      main_q <= skid_q;
            if (push && !pop && count_q == 2'd1)  skid_q <= dec;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = main_q.op;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_imm     = {{(XLEN-12){main_q.imm[11]}}, main_q.imm};
    assign bus.out_use_imm = main_q.use_imm;
    assign bus.out_is_word = main_q.is_word;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench: an RV64+M and an RV32-without-M stage driven in lockstep,
// checked every cycle against a mask/match opcode table and a queue model of the buffer.
module tb_alu_decode_stage;
    import mj32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_decode_stage_if #(.XLEN(64)) bus64 ();
    alu_decode_stage_if #(.XLEN(32)) bus32 ();

    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.out_ready = out_ready;

    alu_decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64)
    );

    alu_decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32)
    );

    // ---------------- reference decoder: first matching table rule wins ----------------
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          op;
        bit          imm;
        bit          word;
        int          xlen_req;   // 0 = any XLEN
        bit          need_m;
    } rule_t;

    typedef struct {
        int          op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        bit          use_imm;
        bit          is_word;
        bit          illegal;
    } exp_t;

    rule_t rules[$];

    function automatic void add_rule(logic [31:0] mask, logic [31:0] match, int op,
                                     bit imm, bit word, int xlen_req, bit need_m);
        rule_t r;
        r.mask = mask; r.match = match; r.op = op; r.imm = imm;
        r.word = word; r.xlen_req = xlen_req; r.need_m = need_m;
        rules.push_back(r);
    endfunction

    function automatic void build_rules();
        int base_ops[8] = '{1, 3, 4, 5, 6, 7, 9, 10};
        for (int f3 = 0; f3 < 8; f3++) begin
            add_rule(32'hFE00707F, 32'h00000033 | (f3 << 12), base_ops[f3], 0, 0, 0, 0);
            add_rule(32'hFE00707F, 32'h02000033 | (f3 << 12), 11 + f3, 0, 0, 0, 1);
            if (f3 != 1 && f3 != 5)
                add_rule(32'h0000707F, 32'h00000013 | (f3 << 12), base_ops[f3], 1, 0, 0, 0);
        end
        add_rule(32'hFE00707F, 32'h40000033, 2, 0, 0, 0, 0);
        add_rule(32'hFE00707F, 32'h40005033, 8, 0, 0, 0, 0);
        add_rule(32'hFE00707F, 32'h00001013, 3, 1, 0, 32, 0);
        add_rule(32'hFE00707F, 32'h00005013, 7, 1, 0, 32, 0);
        add_rule(32'hFE00707F, 32'h40005013, 8, 1, 0, 32, 0);
        add_rule(32'hFC00707F, 32'h00001013, 3, 1, 0, 64, 0);
        add_rule(32'hFC00707F, 32'h00005013, 7, 1, 0, 64, 0);
        add_rule(32'hFC00707F, 32'h40005013, 8, 1, 0, 64, 0);
        add_rule(32'hFE00707F, 32'h0000003B, 1, 0, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h4000003B, 2, 0, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h0000103B, 3, 0, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h0000503B, 7, 0, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h4000503B, 8, 0, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h0200003B, 11, 0, 1, 64, 1);
        add_rule(32'hFE00707F, 32'h0200403B, 15, 0, 1, 64, 1);
        add_rule(32'hFE00707F, 32'h0200503B, 16, 0, 1, 64, 1);
        add_rule(32'hFE00707F, 32'h0200603B, 17, 0, 1, 64, 1);
        add_rule(32'hFE00707F, 32'h0200703B, 18, 0, 1, 64, 1);
        add_rule(32'h0000707F, 32'h0000001B, 1, 1, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h0000101B, 3, 1, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h0000501B, 7, 1, 1, 64, 0);
        add_rule(32'hFE00707F, 32'h4000501B, 8, 1, 1, 64, 0);
    endfunction

    function automatic exp_t ref_decode(logic [31:0] instr, int xlen, bit en_m);
        exp_t e;
        e.op = 0; e.imm = 64'd0; e.use_imm = 0; e.is_word = 0; e.illegal = 1;
        e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
        foreach (rules[i]) begin
            if ((instr & rules[i].mask) == rules[i].match &&
                (rules[i].xlen_req == 0 || rules[i].xlen_req == xlen) &&
                (!rules[i].need_m || en_m)) begin
                e.op = rules[i].op;
                e.illegal = 0;
                e.use_imm = rules[i].imm;
                e.is_word = rules[i].word;
                if (rules[i].imm) begin
                    e.imm = 64'($signed(instr[31:20]));
                    if (xlen == 32) e.imm = e.imm & 64'hFFFF_FFFF;
                end
                return e;
            end
        end
        return e;
    endfunction

    // ---------------- buffer model: queue of accepted instructions ----------------
    logic [31:0] model_q[$];
    bit          fresh_reset = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(string tag, int xlen, bit en_m, logic ov, logic ir,
                             logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic [63:0] imm, logic ui, logic iw, logic il);
        exp_t e;
        check({tag, ".out_valid"}, 64'(ov), 64'(model_q.size() != 0));
        check({tag, ".in_ready"}, 64'(ir), 64'(model_q.size() < 2));
        if (model_q.size() != 0) begin
            e = ref_decode(model_q[0], xlen, en_m);
            check({tag, ".op"}, 64'(op), 64'(e.op));
            check({tag, ".regs"}, {49'd0, rd, rs1, rs2}, {49'd0, e.rd, e.rs1, e.rs2});
            check({tag, ".imm"}, imm, e.imm);
            check({tag, ".flags"}, {61'd0, ui, iw, il}, {61'd0, e.use_imm, e.is_word, e.illegal});
        end else if (fresh_reset) begin
            check({tag, ".reset_payload"}, {ui, iw, il, op, rd, rs1, rs2} | imm, 64'd0);
        end
    endtask

    task automatic check_all();
        check_dut("rv64m", 64, 1'b1, bus64.out_valid, bus64.in_ready, bus64.out_op,
                  bus64.out_rd, bus64.out_rs1, bus64.out_rs2, bus64.out_imm,
                  bus64.out_use_imm, bus64.out_is_word, bus64.out_illegal);
        check_dut("rv32", 32, 1'b0, bus32.out_valid, bus32.in_ready, bus32.out_op,
                  bus32.out_rd, bus32.out_rs1, bus32.out_rs2, 64'(bus32.out_imm),
                  bus32.out_use_imm, bus32.out_is_word, bus32.out_illegal);
    endtask

    // one clock: model the handshake from current inputs, then compare just after the edge
    task automatic step();
        bit          push = in_valid && (model_q.size() < 2);
        bit          pop  = (model_q.size() != 0) && out_ready;
        logic [31:0] instr = in_instr;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            fresh_reset = 1'b1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(instr);
                fresh_reset = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs[5] = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h03};
        logic [6:0]  f7s[5]  = '{7'h00, 7'h20, 7'h01, 7'h21, 7'h00};
        logic [31:0] r = $urandom;
        logic [6:0]  f7 = f7s[$urandom_range(0, 4)];
        if ($urandom_range(0, 5) == 0) f7 = r[31:25];
        return {f7, r[24:7], opcs[$urandom_range(0, 4)]};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        int          op64;
        bit          ill64;
        bit          word64;
        bit          uimm64;
        logic [63:0] imm64;
        int          op32;
        bit          ill32;
    } vec_t;

    initial begin
        vec_t vecs[$];
        vecs.push_back('{"sub",      32'h40B50533,  2, 0, 0, 0, 64'd0,   2, 0});
        vecs.push_back('{"addi",     32'hFFF50513,  1, 0, 0, 1, '1,      1, 0});
        vecs.push_back('{"mul",      32'h02B50533, 11, 0, 0, 0, 64'd0,   0, 1});
        vecs.push_back('{"slli_sh5", 32'h02051513,  3, 0, 0, 1, 64'h20,  0, 1});
        vecs.push_back('{"sraiw",    32'h4015551B,  8, 0, 1, 1, 64'h401, 0, 1});
        vecs.push_back('{"addw",     32'h00B5053B,  1, 0, 1, 0, 64'd0,   0, 1});
        vecs.push_back('{"srai3",    32'h40355513,  8, 0, 0, 1, 64'h403, 8, 0});
        vecs.push_back('{"srai33",   32'h42155513,  8, 0, 0, 1, 64'h421, 0, 1});
        vecs.push_back('{"alt_sll",  32'h40B51533,  0, 1, 0, 0, 64'd0,   0, 1});
        vecs.push_back('{"lw",       32'h00052503,  0, 1, 0, 0, 64'd0,   0, 1});
        vecs.push_back('{"divuw",    32'h02B5553B, 16, 0, 1, 0, 64'd0,   0, 1});
        vecs.push_back('{"mulhw",    32'h02B5153B,  0, 1, 0, 0, 64'd0,   0, 1});
        vecs.push_back('{"and",      32'h00B57533, 10, 0, 0, 0, 64'd0,  10, 0});
        vecs.push_back('{"sltiu",    32'h00153513,  5, 0, 0, 1, 64'h1,   5, 0});
        vecs.push_back('{"slli_alt", 32'h40051513,  0, 1, 0, 0, 64'd0,   0, 1});

        build_rules();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'hDEAD_BEEF; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset.in_ready", 64'(bus64.in_ready), 64'd1);
        check("reset.out_valid", 64'(bus64.out_valid), 64'd0);
        check("reset.out_op", 64'(bus32.out_op), 64'd0);

        // table: one instruction per cycle with execute always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_instr = vecs[i].instr;
            step();
            check({vecs[i].name, ".op64"}, 64'(bus64.out_op), 64'(vecs[i].op64));
            check({vecs[i].name, ".ill64"}, 64'(bus64.out_illegal), 64'(vecs[i].ill64));
            check({vecs[i].name, ".word64"}, 64'(bus64.out_is_word), 64'(vecs[i].word64));
            check({vecs[i].name, ".uimm64"}, 64'(bus64.out_use_imm), 64'(vecs[i].uimm64));
            check({vecs[i].name, ".imm64"}, bus64.out_imm, vecs[i].imm64);
            check({vecs[i].name, ".op32"}, 64'(bus32.out_op), 64'(vecs[i].op32));
            check({vecs[i].name, ".ill32"}, 64'(bus32.out_illegal), 64'(vecs[i].ill32));
            if (i == 0)
                check("sub.regs", {49'd0, bus64.out_rd, bus64.out_rs1, bus64.out_rs2},
                      {49'd0, 5'd10, 5'd10, 5'd11});
            if (!vecs[i].ill32 && vecs[i].uimm64)
                check({vecs[i].name, ".imm32"}, 64'(bus32.out_imm), {32'd0, vecs[i].imm64[31:0]});
        end
        in_valid = 1'b0;
        step();

        // back-pressure: ADD, SUB, XOR, AND offered back to back, execute stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00B50533;
        step();
        check("bp.ready_after1", 64'(bus64.in_ready), 64'd1);
        in_instr = 32'h40B50533;
        step();
        check("bp.ready_after2", 64'(bus64.in_ready), 64'd0);
        check("bp.hold_first", 64'(bus64.out_op), 64'd1);
        in_instr = 32'h00B54533;
        step();
        check("bp.still_full", 64'(bus32.in_ready), 64'd0);
        check("bp.still_first", 64'(bus32.out_op), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp.drain_sub", 64'(bus64.out_op), 64'd2);
        step();
        check("bp.drain_xor", 64'(bus64.out_op), 64'd6);
        in_instr = 32'h00B57533;
        step();
        check("bp.drain_and", 64'(bus64.out_op), 64'd10);
        in_valid = 1'b0;
        step();
        check("bp.empty", 64'(bus64.out_valid), 64'd0);

        // flush with a full buffer and an input offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00B50533;
        step();
        in_instr = 32'h40B50533;
        step();
        flush    = 1'b1;
        in_instr = 32'h00B54533;
        step();
        check("flush.out_valid", 64'(bus64.out_valid), 64'd0);
        check("flush.in_ready", 64'(bus64.in_ready), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush.nothing_emitted", 64'(bus32.out_valid), 64'd0);
        end

        // reset in the middle of traffic clears payload as well
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h4015551B;
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("midrst.op", 64'(bus64.out_op), 64'd0);
        check("midrst.imm", bus64.out_imm, 64'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            in_instr  = rand_instr();
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
